// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU: opcodes, ALU select codes, control FSM
// states and the decoded-instruction word passed from mcu_decode to the FSM.
package mcu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'h9;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } aluOp_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } ctrlState_t;

    typedef enum logic [1:0] {
        COND_ALWAYS,
        COND_Z,
        COND_C
    } jmpCond_t;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } instr_t;

    typedef struct packed {
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } operands_t;

    typedef struct packed {
        aluOp_t   insSel;
        logic     isAlu;
        logic     isLdi;
        logic     isJmp;
        jmpCond_t cond;
        logic     isHlt;
        logic     illegal;
    } decoded_t;

    localparam decoded_t DEC_NOP = '{
        insSel:  ALU_ADD,
        isAlu:   1'b0,
        isLdi:   1'b0,
        isJmp:   1'b0,
        cond:    COND_ALWAYS,
        isHlt:   1'b0,
        illegal: 1'b0
    };

    function automatic logic condMet(input jmpCond_t cond, input logic flagC, input logic flagZ);
        logic met;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_Z:      met = flagZ;
            COND_C:      met = flagC;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/mcu_if.sv
// Control-unit bus: program-memory fetch, ALU select/flags and register-file controls.
// master = control unit, slave = datapath (program memory, register file, ALU).
interface mcu_if;
    import mcu_pkg::*;

    logic        Run;
    logic [7:0]  ProgAddr;
    logic [15:0] InstrIn;
    logic        CO;
    logic        Z;
    aluOp_t      InsSel;
    logic [1:0]  RdAddrA;
    logic [1:0]  RdAddrB;
    logic [1:0]  WrAddr;
    logic        RegWrEn;
    logic        WrSel;
    logic [7:0]  ImmOut;
    logic        FlagC;
    logic        FlagZ;
    logic        Halted;
    logic        Illegal;

    modport master (
        input  Run, InstrIn, CO, Z,
        output ProgAddr, InsSel, RdAddrA, RdAddrB, WrAddr, RegWrEn, WrSel,
               ImmOut, FlagC, FlagZ, Halted, Illegal
    );

    modport slave (
        output Run, InstrIn, CO, Z,
        input  ProgAddr, InsSel, RdAddrA, RdAddrB, WrAddr, RegWrEn, WrSel,
               ImmOut, FlagC, FlagZ, Halted, Illegal
    );

endinterface

// File: rtl/mcu_decode.sv
// Opcode decoder: maps the 4-bit opcode to ALU select and instruction-class flags.
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [3:0] op,
    output decoded_t   dec
);

    always_comb begin
        // NOTE: assigning the full default first means every field is driven on every path, so no latch is inferred.
        dec = DEC_NOP;
        case (op)
            OP_NOP: ;
            OP_ADD: begin dec.isAlu = 1'b1; dec.insSel = ALU_ADD; end
            OP_SUB: begin dec.isAlu = 1'b1; dec.insSel = ALU_SUB; end
            OP_AND: begin dec.isAlu = 1'b1; dec.insSel = ALU_AND; end
            OP_OR:  begin dec.isAlu = 1'b1; dec.insSel = ALU_OR;  end
            OP_LDI: dec.isLdi = 1'b1;
            OP_JMP: begin dec.isJmp = 1'b1; dec.cond = COND_ALWAYS; end
            OP_JZ:  begin dec.isJmp = 1'b1; dec.cond = COND_Z;      end
            OP_JC:  begin dec.isJmp = 1'b1; dec.cond = COND_C;      end
            OP_HLT: dec.isHlt = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcu_control_unit.sv
// Multi-cycle MCU control unit: FETCH/DECODE/EXECUTE/WRITEBACK sequencer with PC,
// pre-decoded instruction register and carry/zero flag register.
module mcu_control_unit
    import mcu_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    mcu_if.master bus
);

    ctrlState_t state;
    logic [7:0] pc;
    operands_t  operands;
    decoded_t   dec;
    decoded_t   decNext;
    instr_t     fetched;
    logic       flagC;
    logic       flagZ;
    logic       regWrEnQ;
    logic       wrSel;
    logic       halted;
    logic       jumpTaken;

    assign fetched = bus.InstrIn;

    // The IR is held pre-decoded: decoding at the load edge lets every control
    // output, including the one-cycle Illegal pulse, come straight from a flop.
    mcu_decode uDecode (
        .op  (fetched.op),
        .dec (decNext)
    );

    assign jumpTaken = dec.isJmp && condMet(dec.cond, flagC, flagZ);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_FETCH;
            pc       <= 8'h00;
            operands <= '0;
            dec      <= DEC_NOP;
            flagC    <= 1'b0;
            flagZ    <= 1'b0;
            regWrEnQ <= 1'b0;
            wrSel    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values, independent of statement order.
            case (state)
                S_FETCH: begin
                    if (bus.Run) state <= S_DECODE;
                end
                S_DECODE: begin
                    operands <= '{rd: fetched.rd, rs: fetched.rs, imm: fetched.imm};
                    dec      <= decNext;
                    pc       <= pc + 8'd1;
                    state    <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    // The decoded illegal bit doubles as the Illegal output, so it lives for EXECUTE only.
                    dec.illegal <= 1'b0;
                    if (dec.isAlu) begin
                        flagC <= bus.CO;
                        flagZ <= bus.Z;
                    end
                    if (jumpTaken) pc <= operands.imm;
                    regWrEnQ <= dec.isAlu | dec.isLdi;
                    wrSel    <= dec.isLdi;
                    if (dec.isHlt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state  <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    regWrEnQ <= 1'b0;
                    wrSel    <= 1'b0;
                    state    <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.ProgAddr = pc;
    assign bus.InsSel   = dec.insSel;
    assign bus.RdAddrA  = operands.rd;
    assign bus.RdAddrB  = operands.rs;
    assign bus.WrAddr   = operands.rd;
    assign bus.ImmOut   = operands.imm;
    // The RF captures on the edge that ends WRITEBACK; gating with RST lets a
    // reset on that same edge cancel the write.
    assign bus.RegWrEn  = regWrEnQ & ~RST;
    assign bus.WrSel    = wrSel;
    assign bus.FlagC    = flagC;
    assign bus.FlagZ    = flagZ;
    assign bus.Halted   = halted;
    assign bus.Illegal  = dec.illegal;

endmodule

// File: tb/tb_mcu_control_unit.sv
// Bench for mcu_control_unit: ROM, register file and ALU around the DUT, checked
// against an instruction-level reference model of the MCU.
module tb_mcu_control_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mcu_if bus ();

    mcu_control_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Datapath around the control unit.
    logic [15:0] rom [256];
    logic [7:0]  rf [4] = '{default: 8'h00};
    logic [8:0]  aluOut;

    function automatic logic [8:0] aluFn(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {a < b, a - b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    always_comb aluOut = aluFn(bus.InsSel, rf[bus.RdAddrA], rf[bus.RdAddrB]);
    assign bus.CO = aluOut[8];
    assign bus.Z  = (aluOut[7:0] == 8'h00);

    initial bus.InstrIn = 16'h0000;
    always @(posedge clk) bus.InstrIn <= rom[bus.ProgAddr];
    always @(posedge clk) if (bus.RegWrEn) rf[bus.WrAddr] <= bus.WrSel ? bus.ImmOut : aluOut[7:0];

    // Instruction-level reference model.
    logic [7:0] mPc;
    logic [7:0] mRf [4];
    logic       mC;
    logic       mZ;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 8'h00;
        mC  = 1'b0;
        mZ  = 1'b0;
    endtask

    task automatic modelStep(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [8:0] r;
        op  = ins[15:12];
        rd  = ins[11:10];
        rs  = ins[9:8];
        imm = ins[7:0];
        mPc = mPc + 8'd1;
        if (op >= 4'd1 && op <= 4'd4) begin
            r       = aluFn(2'(op - 4'd1), mRf[rd], mRf[rs]);
            mRf[rd] = r[7:0];
            mC      = r[8];
            mZ      = (r[7:0] == 8'h00);
        end else begin
            case (op)
                4'd5: mRf[rd] = imm;
                4'd6: mPc = imm;
                4'd7: if (mZ) mPc = imm;
                4'd8: if (mC) mPc = imm;
                default: ;
            endcase
        end
    endtask

    task automatic clearRom();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    endtask

    // Leaves the bench at a falling edge with the DUT sitting in FETCH.
    task automatic doReset();
        rst     = 1'b1;
        bus.Run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic checkResetVals();
        check("rst_progaddr", bus.ProgAddr, 8'h00);
        check("rst_addrs", {bus.InsSel, bus.RdAddrA, bus.RdAddrB, bus.WrAddr}, 8'h00);
        check("rst_imm", bus.ImmOut, 8'h00);
        check("rst_strobes", {bus.RegWrEn, bus.WrSel, bus.Halted, bus.Illegal}, 4'h0);
        check("rst_flags", {bus.FlagC, bus.FlagZ}, 2'b00);
    endtask

    // Runs the instruction at the model PC, checking every cycle. Entered and left
    // at a falling edge in FETCH (or in HALT after HLT).
    task automatic runInstr();
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  expSel;
        logic        writes;
        ins    = rom[mPc];
        op     = ins[15:12];
        expSel = (op >= 4'd1 && op <= 4'd4) ? 2'(op - 4'd1) : 2'b00;
        writes = (op >= 4'd1 && op <= 4'd5);
        check("fetch_addr", bus.ProgAddr, mPc);
        bus.Run = 1'b1;
        @(negedge clk);
        check("decode_strobes", {bus.RegWrEn, bus.Illegal, bus.Halted}, 3'b000);
        @(negedge clk);
        check("exec_illegal", bus.Illegal, op >= 4'd10);
        check("exec_inssel", bus.InsSel, expSel);
        check("exec_rdaddr", {bus.RdAddrA, bus.RdAddrB}, ins[11:8]);
        check("exec_wren", bus.RegWrEn, 1'b0);
        modelStep(ins);
        @(negedge clk);
        check("wb_wren", bus.RegWrEn, writes);
        check("wb_inssel_held", bus.InsSel, expSel);
        check("wb_halted", bus.Halted, op == 4'd9);
        check("wb_illegal", bus.Illegal, 1'b0);
        check("wb_flags", {bus.FlagC, bus.FlagZ}, {mC, mZ});
        if (writes) begin
            check("wb_wrsel", bus.WrSel, op == 4'd5);
            check("wb_wraddr_imm", {bus.WrAddr, bus.ImmOut}, {ins[11:10], ins[7:0]});
        end
        if (op != 4'd9) begin
            @(negedge clk);
            check("next_pc", bus.ProgAddr, mPc);
            check("rf_state", {rf[0], rf[1], rf[2], rf[3]}, {mRf[0], mRf[1], mRf[2], mRf[3]});
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [1:0]  sel;
        logic        wr;
        logic        wrSel;
        logic        ill;
        logic [7:0]  nextPc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[1]  = '{16'h1600, 2'b00, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[2]  = '{16'h2C00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[3]  = '{16'h3900, 2'b10, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[4]  = '{16'h4300, 2'b11, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[5]  = '{16'h5833, 2'b00, 1'b1, 1'b1, 1'b0, 8'h01};
        vecs[6]  = '{16'h6042, 2'b00, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[7]  = '{16'h7055, 2'b00, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[8]  = '{16'h8066, 2'b00, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[9]  = '{16'hB123, 2'b00, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[10] = '{16'hF0FF, 2'b00, 1'b0, 1'b0, 1'b1, 8'h01};

        for (int i = 0; i < 4; i++) mRf[i] = 8'h00;
        clearRom();
        rst     = 1'b1;
        bus.Run = 1'b0;
        repeat (3) @(negedge clk);
        checkResetVals();
        rst = 1'b0;
        modelReset();

        // Single-instruction decode table, each from reset (flags clear).
        for (int i = 0; i < 11; i++) begin
            clearRom();
            rom[0] = vecs[i].instr;
            doReset();
            bus.Run = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("tbl_inssel", bus.InsSel, vecs[i].sel);
            check("tbl_illegal", bus.Illegal, vecs[i].ill);
            modelStep(vecs[i].instr);
            @(negedge clk);
            check("tbl_wren", bus.RegWrEn, vecs[i].wr);
            if (vecs[i].wr) check("tbl_wrsel", bus.WrSel, vecs[i].wrSel);
            @(negedge clk);
            check("tbl_next_pc", bus.ProgAddr, vecs[i].nextPc);
        end

        // LDI R0,5; LDI R1,5; ADD R0,R1
        clearRom();
        rom[0] = 16'h5005;
        rom[1] = 16'h5405;
        rom[2] = 16'h1100;
        doReset();
        repeat (3) runInstr();
        check("seq1_r0", rf[0], 8'h0A);
        check("seq1_flags", {bus.FlagC, bus.FlagZ}, 2'b00);

        // LDI R0,8; LDI R1,8; SUB R0,R1; JZ 0x20
        clearRom();
        rom[0] = 16'h5008;
        rom[1] = 16'h5408;
        rom[2] = 16'h2100;
        rom[3] = 16'h7020;
        doReset();
        repeat (4) runInstr();
        check("seq2_flagz", bus.FlagZ, 1'b1);
        check("seq2_jz_target", bus.ProgAddr, 8'h20);

        // LDI R0,FF; LDI R1,1; ADD R0,R1; JC 0x40; LDI R2,7; then stall, illegal, HLT
        clearRom();
        rom[0]     = 16'h50FF;
        rom[1]     = 16'h5401;
        rom[2]     = 16'h1100;
        rom[3]     = 16'h8040;
        rom[8'h40] = 16'h5807;
        rom[8'h41] = 16'hB000;
        rom[8'h42] = 16'h9000;
        doReset();
        repeat (4) runInstr();
        check("seq3_flagc", bus.FlagC, 1'b1);
        check("seq3_jc_target", bus.ProgAddr, 8'h40);
        runInstr();
        check("seq3_ldi_keeps_c", bus.FlagC, 1'b1);
        check("seq3_r2", rf[2], 8'h07);

        bus.Run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_addr", bus.ProgAddr, mPc);
            check("stall_strobes", {bus.RegWrEn, bus.Illegal, bus.Halted}, 3'b000);
            check("stall_flags", {bus.FlagC, bus.FlagZ}, {mC, mZ});
        end
        check("stall_rf", {rf[0], rf[1], rf[2], rf[3]}, {mRf[0], mRf[1], mRf[2], mRf[3]});
        runInstr();
        check("illegal_pc_plus1", bus.ProgAddr, 8'h42);
        runInstr();
        for (int c = 0; c < 8; c++) begin
            bus.Run = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_halted", bus.Halted, 1'b1);
            check("halt_addr", bus.ProgAddr, 8'h43);
            check("halt_strobes", {bus.RegWrEn, bus.Illegal}, 2'b00);
        end
        doReset();
        check("halt_cleared", bus.Halted, 1'b0);

        // Reset during WRITEBACK of LDI R2,0x33 cancels the write.
        clearRom();
        rom[0] = 16'h5811;
        rom[1] = 16'h5833;
        doReset();
        runInstr();
        check("wbrst_fetch", bus.ProgAddr, 8'h01);
        bus.Run = 1'b1;
        repeat (3) @(negedge clk);
        check("wbrst_pending", bus.RegWrEn, 1'b1);
        rst = 1'b1;
        #1;
        check("wbrst_gated", bus.RegWrEn, 1'b0);
        @(negedge clk);
        checkResetVals();
        check("wbrst_r2_kept", rf[2], 8'h11);
        rst = 1'b0;
        modelReset();
        runInstr();

        // Random programs with random FETCH stalls.
        for (int a = 0; a < 256; a++) begin
            logic [31:0] r;
            logic [3:0]  op;
            r  = $urandom();
            op = 4'($urandom_range(0, 14));
            if (op >= 4'd9) op = op + 4'd1;
            rom[a] = {op, r[11:0]};
        end
        doReset();
        for (int n = 0; n < 150; n++) begin
            int stall;
            stall   = $urandom_range(0, 2);
            bus.Run = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("rnd_stall_addr", bus.ProgAddr, mPc);
            end
            runInstr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
